// File: rtl/pc_sequencer_pkg.sv
// Shared op encodings and default constants for the PC sequencer.
package pc_sequencer_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD   = 3'b000;
    localparam logic [OP_W-1:0] OP_INC    = 3'b001;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'b010;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'b011;
    localparam logic [OP_W-1:0] OP_CALL   = 3'b100;
    localparam logic [OP_W-1:0] OP_RET    = 3'b101;

    localparam logic [31:0]     DEF_RESET_VALUE = 32'h0006_0000;
    localparam int unsigned     DEF_STEP        = 4;
    localparam int unsigned     DEF_RAS_DEPTH   = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [CNT_W-1:0] cnt;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign top   = mem[wp - PTR_W'(1)];

    // Storage needs no reset; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push) begin
            wp <= wp + PTR_W'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                wp  <= wp - PTR_W'(1);
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with optional return-address stack.
// Define PC_SEQUENCER_RAS_EN to build the stack; otherwise CALL=JUMP and RET=INC.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(DEF_RESET_VALUE),
    parameter int unsigned       STEP        = DEF_STEP,
    parameter int unsigned       RAS_DEPTH   = DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_ovf,
    output logic             ras_unf
);

    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] pc_brn;
    logic [WIDTH-1:0] pc_nxt;

    assign pc_seq = out + WIDTH'(STEP);
    assign pc_brn = out + {in[WIDTH-3:0], 2'b00};

`ifdef PC_SEQUENCER_RAS_EN
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] ras_top;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .data  (pc_seq),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    // Next-PC select; stack ops are gated by stall so a held cycle is inert.
    always_comb begin
        pc_nxt = out;
        push   = 1'b0;
        pop    = 1'b0;
        if (!stall) begin
            case (op)
                OP_INC:    pc_nxt = pc_seq;
                OP_JUMP:   pc_nxt = in;
                OP_BRANCH: pc_nxt = pc_brn;
                OP_CALL: begin
                    pc_nxt = in;
                    push   = 1'b1;
                end
                OP_RET: begin
                    pc_nxt = ras_empty ? pc_seq : ras_top;
                    pop    = 1'b1;
                end
                default:   pc_nxt = out;
            endcase
        end
    end
`else
    assign ras_full  = 1'b0;
    assign ras_empty = 1'b1;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;

    // Without a stack, CALL degenerates to JUMP and RET to INC.
    always_comb begin
        pc_nxt = out;
        if (!stall) begin
            case (op)
                OP_INC, OP_RET:   pc_nxt = pc_seq;
                OP_JUMP, OP_CALL: pc_nxt = in;
                OP_BRANCH:        pc_nxt = pc_brn;
                default:          pc_nxt = out;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            out <= RESET_VALUE;
        end else begin
            out <= pc_nxt;
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, PC and target width in bits.
REQ-002 Parameter RESET_VALUE, default 32'h00060000, PC value after reset (ROM base).
REQ-003 Parameter STEP, default 4, sequential increment in bytes.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 stall  input  1  1 = hold all state, op ignored.
REQ-008 op  input  3  next-PC select (encoding in Function).
REQ-009 in  input  WIDTH  absolute target (JUMP/CALL) or word offset (BRANCH).
REQ-010 out  output  WIDTH  current PC, registered.
REQ-011 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-012 ras_empty  output  1  stack holds 0 entries.
REQ-013 ras_ovf  output  1  sticky, a CALL occurred while full.
REQ-014 ras_unf  output  1  sticky, a RET occurred while empty.

Function
REQ-015 op 000 HOLD: out unchanged.
REQ-016 op 001 INC: out <= out + STEP.
REQ-017 op 010 JUMP: out <= in.
REQ-018 op 011 BRANCH: out <= out + {in[WIDTH-3:0],2'b00}; two's-complement offset, sum truncated to WIDTH (modular wrap).
REQ-019 op 100 CALL: push out + STEP onto stack; out <= in; same cycle.
REQ-020 op 101 RET: pop top entry; out <= popped value; same cycle.
REQ-021 op 110/111 reserved: behave as HOLD, no stack change.
REQ-022 All adds truncated to WIDTH; out + STEP from all-ones wraps to STEP-1.
REQ-023 Latency: op/in sampled at edge N, new out visible after edge N; one op per cycle.
REQ-024 stall=1: out, stack, count and flags unchanged regardless of op.
REQ-025 CALL while full: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_ovf set to 1.
REQ-026 RET while empty: out <= out + STEP, stack unchanged, ras_unf set to 1.
REQ-027 ras_full/ras_empty combinational from entry count; ras_full and ras_empty never both 1.
REQ-028 ras_ovf/ras_unf cleared only by reset.

Reset
REQ-029 rst=0 at rising edge: out <= RESET_VALUE, count <= 0, ras_ovf <= 0, ras_unf <= 0; stack contents don't-care.
REQ-030 Reset overrides stall and op; reset mid-CALL/RET discards that operation.
REQ-031 First op after rst returns to 1 acts on RESET_VALUE.

Configuration
REQ-032 Macro PC_SEQUENCER_RAS_EN defined: stack and REQ-019/020/025/026 as specified.
REQ-033 Macro undefined: no stack storage; CALL behaves as JUMP; RET behaves as INC; ras_full=0, ras_empty=1, ras_ovf=0, ras_unf=0 constant.

Structure
REQ-034 Shared package holds op encoding constants (OP_HOLD..OP_RET) and default RESET_VALUE/STEP constants.
REQ-035 Return-address stack implemented as sub-module pc_ras (push, pop, top, full, empty, circular overwrite), instanced only under PC_SEQUENCER_RAS_EN.

Verification
REQ-036 rst=0 one cycle, then op=INC x3 -> out 0x00060000, 0x00060004, 0x00060008, 0x0006000C.
REQ-037 out=0x00060010, op=BRANCH in=0xFFFFFFFE -> out=0x00060008; op=JUMP in=0x00061000 -> out=0x00061000.
REQ-038 out=0x00060000, CALL in=0x00062000, INC, RET -> out 0x00062000, 0x00062004, 0x00060004; ras_empty=1 at end.
REQ-039 Five CALLs (RAS_DEPTH=4) then five RETs -> ras_ovf=1 after 5th CALL; four RETs return last four addresses LIFO; fifth RET gives out+4, ras_unf=1.
REQ-040 stall=1 with op=CALL for 3 cycles -> out, ras_empty, flags unchanged; stall=0 -> CALL takes effect next edge.
REQ-041 out=0xFFFFFFFC op=INC -> out=0x00000000; then rst=0 concurrent with op=RET -> out=0x00060000, flags 0.
